// File: rtl/trap_ctrl.sv
// Trap and MRET sequencer: on an exception, interrupt or MRET at the execute
// boundary it stalls the pipeline and steps through the CSR trap port one
// write per cycle, then redirects the PC.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_trap_i,
    input  logic        tcmp_tarp_i,
    input  logic        soft_trap_i,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_pc_i,
    input  logic [31:0] inst_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic [31:0] mepc_i,
    output logic        trap_csr_we_o,
    output logic [11:0] trap_csr_addr_o,
    output logic [31:0] trap_csr_wdata_o,
    input  logic [31:0] trap_csr_rdata_i,
    output logic        hold_o,
    output logic        flush_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam logic [11:0] CsrMtval   = 12'h343;

    typedef enum logic [2:0] {
        StIdle, StWMepc, StWMcause, StWMtval, StWMstatus, StTJump, StRMstatus, StRJump
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;

    logic        exc_hit;
    logic        irq_any;
    logic        take_trap;
    logic        take_mret;
    logic [31:0] new_cause;
    logic [31:0] new_tval;

    // Low mtvec bits are forced to zero in the jump target and never looked at.
    logic unused_rdata;
    assign unused_rdata = ^trap_csr_rdata_i[1:0];

    // Acceptance decode; in IDLE the port points at mstatus so rdata[3] is MIE.
    always_comb begin
        exc_hit   = inst_valid_i & (illegal_i | ebreak_i | ecall_i);
        irq_any   = ex_trap_i | soft_trap_i | tcmp_tarp_i;
        take_trap = 1'b0;
        take_mret = 1'b0;
        if (!rst && state_q == StIdle) begin
            take_trap = exc_hit |
                        (inst_valid_i & ~mret_i & trap_csr_rdata_i[3] & irq_any);
            take_mret = ~exc_hit & inst_valid_i & mret_i;
        end
        new_cause = 32'h0;
        new_tval  = 32'h0;
        if (inst_valid_i && illegal_i) begin
            new_cause = 32'h0000_0002;
            new_tval  = inst_i;
        end else if (inst_valid_i && ebreak_i) begin
            new_cause = 32'h0000_0003;
            new_tval  = inst_pc_i;
        end else if (inst_valid_i && ecall_i) begin
            new_cause = 32'h0000_000B;
        end else if (ex_trap_i) begin
            new_cause = 32'h8000_000B;
        end else if (soft_trap_i) begin
            new_cause = 32'h8000_0003;
        end else begin
            new_cause = 32'h8000_0007;
        end
        cause_d = take_trap ? new_cause : cause_q;
        epc_d   = take_trap ? inst_pc_i : epc_q;
        tval_d  = take_trap ? new_tval  : tval_q;
    end

    // State and captured trap context, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cause_q <= 32'h0;
            epc_q   <= 32'h0;
            tval_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

    // Next state: every non-IDLE state lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_trap)      state_d = StWMepc;
                else if (take_mret) state_d = StRMstatus;
            end
            StWMepc:    state_d = StWMcause;
            StWMcause:  state_d = StWMtval;
            StWMtval:   state_d = StWMstatus;
            StWMstatus: state_d = StTJump;
            StTJump:    state_d = StIdle;
            StRMstatus: state_d = StRJump;
            StRJump:    state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs: CSR port drive, stall, flush and redirect per state.
    always_comb begin
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = CsrMstatus;
        trap_csr_wdata_o = 32'h0;
        hold_o           = 1'b0;
        flush_o          = 1'b0;
        jump_o           = 1'b0;
        jump_addr_o      = 32'h0;
        unique case (state_q)
            StIdle: begin
                if (take_trap || take_mret) begin
                    hold_o  = 1'b1;
                    flush_o = 1'b1;
                end
            end
            StWMepc: begin
                hold_o           = 1'b1;
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CsrMepc;
                trap_csr_wdata_o = epc_q;
            end
            StWMcause: begin
                hold_o           = 1'b1;
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CsrMcause;
                trap_csr_wdata_o = cause_q;
            end
            StWMtval: begin
                hold_o           = 1'b1;
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CsrMtval;
                trap_csr_wdata_o = tval_q;
            end
            StWMstatus: begin
                // MPIE <= MIE, MIE <= 0
                hold_o           = 1'b1;
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CsrMstatus;
                trap_csr_wdata_o = {24'h0, trap_csr_rdata_i[3], 3'h0, 1'b0, 3'h0};
            end
            StTJump: begin
                hold_o          = 1'b1;
                trap_csr_addr_o = CsrMtvec;
                jump_o          = 1'b1;
                jump_addr_o     = {trap_csr_rdata_i[31:2], 2'b00};
            end
            StRMstatus: begin
                // MIE <= MPIE, MPIE <= 1
                hold_o           = 1'b1;
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CsrMstatus;
                trap_csr_wdata_o = {24'h0, 1'b1, 3'h0, trap_csr_rdata_i[7], 3'h0};
            end
            StRJump: begin
                hold_o      = 1'b1;
                jump_o      = 1'b1;
                jump_addr_o = mepc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: small CSR file model, expected-output queue model,
// directed scenarios with literal checks on the resulting CSR contents.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_trap, tcmp_trap, soft_trap, inst_valid;
    logic [31:0] inst_pc, inst;
    logic        ecall, ebreak, illegal, mret;
    logic [31:0] mepc;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        hold, flush, jump;
    logic [31:0] jump_addr;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .ex_trap_i        (ex_trap),
        .tcmp_tarp_i      (tcmp_trap),
        .soft_trap_i      (soft_trap),
        .inst_valid_i     (inst_valid),
        .inst_pc_i        (inst_pc),
        .inst_i           (inst),
        .ecall_i          (ecall),
        .ebreak_i         (ebreak),
        .illegal_i        (illegal),
        .mret_i           (mret),
        .mepc_i           (mepc),
        .trap_csr_we_o    (csr_we),
        .trap_csr_addr_o  (csr_addr),
        .trap_csr_wdata_o (csr_wdata),
        .trap_csr_rdata_i (csr_rdata),
        .hold_o           (hold),
        .flush_o          (flush),
        .jump_o           (jump),
        .jump_addr_o      (jump_addr)
    );

    // CSR file model
    logic [31:0] c_mstatus = 0, c_mtvec = 0, c_mepc = 0, c_mcause = 0, c_mtval = 0;
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = 0;
    logic [31:0] pl_data = 0;

    assign mepc = c_mepc;

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            12'h300: csr_rdata = c_mstatus;
            12'h305: csr_rdata = c_mtvec;
            12'h341: csr_rdata = c_mepc;
            12'h342: csr_rdata = c_mcause;
            12'h343: csr_rdata = c_mtval;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        logic [11:0] wa;
        logic [31:0] wd;
        wa = csr_we ? csr_addr : pl_addr;
        wd = csr_we ? csr_wdata : pl_data;
        if (csr_we || pl_we) begin
            case (wa)
                12'h300: c_mstatus <= wd;
                12'h305: c_mtvec   <= wd;
                12'h341: c_mepc    <= wd;
                12'h342: c_mcause  <= wd;
                12'h343: c_mtval   <= wd;
                default: ;
            endcase
        end
    end

    // Expected-output model
    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic        ca;
        logic [31:0] wd;
        logic        hold;
        logic        flush;
        logic        jump;
        logic [31:0] ja;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   jump_cnt = 0;
    logic [31:0] last_ja = 0;
    logic chk_en = 1'b0;

    function automatic exp_t mk(logic we, logic [11:0] addr, logic ca, logic [31:0] wd,
                                logic hold_e, logic flush_e, logic jump_e, logic [31:0] ja);
        exp_t e;
        e.we = we; e.addr = addr; e.ca = ca; e.wd = wd;
        e.hold = hold_e; e.flush = flush_e; e.jump = jump_e; e.ja = ja;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_trap(input logic [31:0] cause, input logic [31:0] tval);
        logic mie;
        mie = c_mstatus[3];
        q.push_back(mk(1'b1, 12'h341, 1'b1, inst_pc, 1'b1, 1'b0, 1'b0, 32'h0));
        q.push_back(mk(1'b1, 12'h342, 1'b1, cause, 1'b1, 1'b0, 1'b0, 32'h0));
        q.push_back(mk(1'b1, 12'h343, 1'b1, tval, 1'b1, 1'b0, 1'b0, 32'h0));
        q.push_back(mk(1'b1, 12'h300, 1'b1, mie ? 32'h80 : 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
        q.push_back(mk(1'b0, 12'h305, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, c_mtvec & ~32'h3));
    endtask

    // Decide what an idle cycle must look like and schedule the sequence it starts.
    task automatic idle_eval(output exp_t e);
        exp_t acc;
        e   = mk(1'b0, 12'h300, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        acc = mk(1'b0, 12'h300, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        if (rst || !inst_valid) return;
        if (illegal) begin
            e = acc; push_trap(32'h2, inst);
        end else if (ebreak) begin
            e = acc; push_trap(32'h3, inst_pc);
        end else if (ecall) begin
            e = acc; push_trap(32'hB, 32'h0);
        end else if (mret) begin
            e = acc;
            q.push_back(mk(1'b1, 12'h300, 1'b1, 32'h8 | (c_mstatus[7] ? 32'h80 : 32'h0),
                           1'b1, 1'b0, 1'b0, 32'h0));
            q.push_back(mk(1'b0, 12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, c_mepc));
        end else if (c_mstatus[3]) begin
            if (ex_trap) begin
                e = acc; push_trap(32'h8000000B, 32'h0);
            end else if (soft_trap) begin
                e = acc; push_trap(32'h80000003, 32'h0);
            end else if (tcmp_trap) begin
                e = acc; push_trap(32'h80000007, 32'h0);
            end
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (q.size() > 0) e = q.pop_front();
            else idle_eval(e);
            check("we", {31'h0, csr_we}, {31'h0, e.we});
            if (e.ca) check("addr", {20'h0, csr_addr}, {20'h0, e.addr});
            check("wdata", csr_wdata, e.wd);
            check("hold", {31'h0, hold}, {31'h0, e.hold});
            check("flush", {31'h0, flush}, {31'h0, e.flush});
            check("jump", {31'h0, jump}, {31'h0, e.jump});
            check("jump_addr", jump_addr, e.ja);
            if (jump) begin
                jump_cnt++;
                last_ja = jump_addr;
            end
            if (rst) q.delete();
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step(1);
        pl_we = 1'b0;
    endtask

    task automatic clr_in();
        ex_trap = 0; tcmp_trap = 0; soft_trap = 0; inst_valid = 0;
        ecall = 0; ebreak = 0; illegal = 0; mret = 0;
    endtask

    int jc;

    initial begin
        rst = 1'b1;
        clr_in();
        inst_pc = 32'h0;
        inst = 32'h0;
        step(2);
        chk_en = 1'b1;
        check("rst_addr", {20'h0, csr_addr}, 32'h300);
        check("rst_hold", {31'h0, hold}, 32'h0);
        rst = 1'b0;
        preload(12'h305, 32'h100);
        preload(12'h300, 32'h08);

        // External interrupt with MIE=1
        inst_pc = 32'h200; ex_trap = 1; inst_valid = 1;
        step(1); clr_in(); step(7);
        check("ext_mepc", c_mepc, 32'h200);
        check("ext_mcause", c_mcause, 32'h8000000B);
        check("ext_mtval", c_mtval, 32'h0);
        check("ext_mstatus", c_mstatus, 32'h80);
        check("ext_jump", last_ja, 32'h100);

        // Illegal instruction with MIE=0
        preload(12'h300, 32'h0);
        inst_pc = 32'h40; inst = 32'hFFFFFFFF; illegal = 1; inst_valid = 1;
        step(1); clr_in(); step(7);
        check("ill_mepc", c_mepc, 32'h40);
        check("ill_mcause", c_mcause, 32'h2);
        check("ill_mtval", c_mtval, 32'hFFFFFFFF);
        check("ill_mstatus", c_mstatus, 32'h0);

        // Ebreak records its PC as mtval
        inst_pc = 32'h44; inst = 32'h00100073; ebreak = 1; inst_valid = 1;
        step(1); clr_in(); step(7);
        check("ebr_mcause", c_mcause, 32'h3);
        check("ebr_mtval", c_mtval, 32'h44);

        // MRET
        preload(12'h300, 32'h80);
        preload(12'h341, 32'h204);
        mret = 1; inst_valid = 1;
        step(1); clr_in(); step(1);
        check("mret_mstatus", c_mstatus, 32'h88);
        check("mret_jump", {31'h0, jump}, 32'h1);
        check("mret_target", jump_addr, 32'h204);
        step(1);
        check("mret_idle", {31'h0, hold}, 32'h0);
        step(4);

        // Ecall beats a simultaneous interrupt; interrupt waits for MIE
        preload(12'h300, 32'h08);
        inst_pc = 32'h300; ecall = 1; ex_trap = 1; inst_valid = 1;
        step(1); ecall = 0; step(5);
        check("ecall_mcause", c_mcause, 32'hB);
        check("ecall_masked", {31'h0, hold}, 32'h0);
        step(3);
        mret = 1;
        step(1); mret = 0; step(9);
        check("irq_after_mret", c_mcause, 32'h8000000B);
        check("irq_mstatus", c_mstatus, 32'h80);
        clr_in(); step(2);

        // Software beats timer; masked with MIE=0
        preload(12'h300, 32'h08);
        soft_trap = 1; tcmp_trap = 1; inst_valid = 1;
        step(1); clr_in(); step(7);
        check("soft_mcause", c_mcause, 32'h80000003);
        soft_trap = 1; tcmp_trap = 1; inst_valid = 1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("masked_hold", {31'h0, hold}, 32'h0);
        end
        clr_in();
        preload(12'h300, 32'h08);
        tcmp_trap = 1; inst_valid = 1;
        step(1); clr_in(); step(7);
        check("tmr_mcause", c_mcause, 32'h80000007);

        // Reset in the middle of a trap sequence
        preload(12'h300, 32'h08);
        preload(12'h343, 32'h5A5A5A5A);
        jc = jump_cnt;
        inst_pc = 32'h80; inst = 32'h1234; illegal = 1; inst_valid = 1;
        step(1); clr_in(); step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("abort_hold", {31'h0, hold}, 32'h0);
        step(6);
        check("abort_mepc", c_mepc, 32'h80);
        check("abort_mcause", c_mcause, 32'h2);
        check("abort_mtval", c_mtval, 32'h5A5A5A5A);
        check("abort_mstatus", c_mstatus, 32'h08);
        check("abort_nojump", jump_cnt, jc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
